// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the pushbutton debouncer.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } key_state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 5000;
  localparam int PRESS_COUNT_W           = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, synchronous reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/key_debouncer.sv
// Pushbutton debouncer: synchronizes an active-low key and accepts a level
// change only after it has been stable for DEBOUNCE_CYCLES cycles.
module key_debouncer
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 13
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     key_n,
  output logic                     key_level,
  output logic                     key_press,
  output logic                     key_release,
  output logic [PRESS_COUNT_W-1:0] press_count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic key_raw;
  logic s;

  key_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic level_q, level_d;
  logic press_q, press_d;
  logic release_q, release_d;
  logic [PRESS_COUNT_W-1:0] count_q, count_d;

  assign key_raw = ~key_n;

  sync_2ff u_sync (
    .clk   (CLOCK_50),
    .reset (reset),
    .d     (key_raw),
    .q     (s)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      count_q   <= count_d;
    end
  end

  // Any disagreement during a WAIT state drops back without touching outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    press_d   = (state_q == PRESS_WAIT)   &&  s && (cnt_q == CNT_LAST);
    release_d = (state_q == RELEASE_WAIT) && !s && (cnt_q == CNT_LAST);
    level_d   = level_q;
    if (press_d) begin
      level_d = 1'b1;
    end else if (release_d) begin
      level_d = 1'b0;
    end
    count_d = count_q + PRESS_COUNT_W'(press_d);
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign press_count = count_q;

endmodule

// File: doc/key_debouncer.md
KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 5000, giving the stable-input cycles required before accepting a change; legal minimum 2.
REQ-002 The block SHALL have parameter CNT_W, default 13, giving the debounce counter width; it SHALL satisfy 2**CNT_W > DEBOUNCE_CYCLES.
REQ-003 The block SHALL have port CLOCK_50  input  1  system clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port key_n  input  1  raw pushbutton, active-low, asynchronous and bouncy.
REQ-006 The block SHALL have port key_level  output  1  debounced pressed level; 1 = pressed.
REQ-007 The block SHALL have port key_press  output  1  one-cycle pulse on each accepted press.
REQ-008 The block SHALL have port key_release  output  1  one-cycle pulse on each accepted release.
REQ-009 The block SHALL have port press_count  output  8  count of accepted presses, for the downstream blinker/display.

Function
REQ-010 The block SHALL pass ~key_n through a 2-flop synchronizer; the second flop output is "s", the only signal the FSM reads.
REQ-011 The FSM SHALL have four states: IDLE (released), PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-012 In IDLE with s=1, the FSM SHALL go to PRESS_WAIT with cnt cleared to 0; with s=0 it SHALL stay in IDLE.
REQ-013 In PRESS_WAIT with s=0, the FSM SHALL return to IDLE with no output activity (bounce rejected).
REQ-014 In PRESS_WAIT with s=1 and cnt<DEBOUNCE_CYCLES-1, cnt SHALL increment.
REQ-015 In PRESS_WAIT with s=1 and cnt==DEBOUNCE_CYCLES-1, the FSM SHALL go to PRESSED, and on that same edge SHALL set key_level=1, key_press=1 and press_count+1.
REQ-016 In PRESSED with s=0, the FSM SHALL go to RELEASE_WAIT with cnt cleared to 0; with s=1 it SHALL stay in PRESSED.
REQ-017 In RELEASE_WAIT with s=1, the FSM SHALL return to PRESSED with no output activity.
REQ-018 In RELEASE_WAIT with s=0, cnt SHALL increment; at cnt==DEBOUNCE_CYCLES-1 the FSM SHALL go to IDLE, set key_level=0 and pulse key_release.
REQ-019 key_press and key_release SHALL be registered, SHALL be high for exactly one cycle, and SHALL never be high together.
REQ-020 Latency: if E0 is the first edge sampling key_n low and key_n then holds, key_press SHALL be high in the cycle after edge E0+2+DEBOUNCE_CYCLES; release latency SHALL be symmetric.
REQ-021 press_count SHALL wrap from 255 to 0 without saturating and without a flag.
REQ-022 key_level SHALL change only on the edges that pulse key_press or key_release.
REQ-023 cnt SHALL be cleared on every entry to a WAIT state and SHALL never exceed DEBOUNCE_CYCLES-1.

Reset
REQ-024 When reset=1 at a clock edge: both synchronizer flops=0, state=IDLE, cnt=0, key_level=0, key_press=0, key_release=0, press_count=0.
REQ-025 reset SHALL take priority over every transition, including a WAIT state at its terminal count; a pending pulse SHALL be suppressed.
REQ-026 If key_n is held low through reset, then after deassertion a full debounce SHALL run again, giving exactly one key_press at latency REQ-020, counted from the first post-reset edge.

Structure
REQ-027 Package key_debounce_pkg SHALL hold the state typedef (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT) and constants DEFAULT_DEBOUNCE_CYCLES=5000 and PRESS_COUNT_W=8.
REQ-028 The synchronizer SHALL be a separate sub-module sync_2ff (1-bit, 2 flops, synchronous reset value 0), reusable across the board design.
REQ-029 The FSM, counter and output registers SHALL live in key_debouncer; there SHALL be no other sub-modules.

Verification (bench parameter DEBOUNCE_CYCLES=4, CNT_W=3)
REQ-030 Clean press: key_n 1->0 sampled at edge 10, held -> key_press high only in the cycle after edge 16; key_level=1 from then on; press_count=1.
REQ-031 Bounce rejection: key_n low for 3 cycles, high for 1 cycle, repeated 5 times, then high -> no key_press; key_level=0; press_count=0.
REQ-032 Press then release: hold low 20 cycles, then high -> one key_press; key_release 6 edges after the first high sample; key_level back to 0; pulses never overlap.
REQ-033 Wrap: 256 clean press/release cycles -> press_count reads 255 after press 255 and 0 after press 256.
REQ-034 Reset mid-PRESS_WAIT: key_n low, reset pulsed at edge E0+4, key_n held -> no pulse before reset; exactly one key_press 6 edges after reset deasserts; press_count=1.
REQ-035 Release bounce: in PRESSED, key_n high 2 cycles then low -> key_level stays 1; no key_release; state returns to PRESSED.
